// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// The command word is what the producer pushes and the FIFO stores.
package alu_seq_pkg;

  localparam int DATA_W = 3;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with synchronous active-low reset.
// A push while full or a pop while empty is ignored.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  cmd_t                  i_push_data,
  input  logic                  i_pop,
  output cmd_t                  o_pop_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;

endmodule

// File: rtl/alu_op_sequencer.sv
// Command stage in front of the 3-bit ALU: queues add/sub commands, drives
// one at a time onto the ALU pins and returns F over a valid/ready channel.
//
// state | meaning
// IDLE  | no command on the ALU; waiting for the FIFO to hold one
// DRIVE | operands stable; ALU samples them on the falling edge
// RESP  | result held on res_f until the consumer takes it
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_sub,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_select,
  input  logic [DATA_W-1:0] alu_f,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_f,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  localparam int PTR_W = $clog2(DEPTH);

  state_t              r_state;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic                r_alu_select;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_f;
  logic [CNT_W-1:0]    r_ops_done;

  cmd_t                w_cmd_in;
  cmd_t                w_head;
  cmd_t                w_next_cmd;
  logic                w_full;
  logic                w_empty;
  logic [PTR_W:0]      w_count;
  logic                w_push;
  logic                w_hs;
  logic                w_bypass;
  logic                w_fifo_push;
  logic                w_pop;

  assign w_cmd_in = '{a: cmd_a, b: cmd_b, sub: cmd_sub};
  assign w_push   = cmd_valid & cmd_ready;
  assign w_hs     = (r_state == RESP) & r_res_valid & res_ready;

  // A command arriving on the handshake edge with an empty FIFO goes
  // straight to the operand regs instead of through the FIFO.
  assign w_bypass    = w_hs & w_empty & w_push;
  assign w_fifo_push = w_push & ~w_bypass;
  assign w_pop       = ((r_state == IDLE) | w_hs) & ~w_empty;
  assign w_next_cmd  = w_bypass ? w_cmd_in : w_head;

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_fifo_push),
    .i_push_data (w_cmd_in),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_select <= SEL_ADD;
      r_res_valid  <= 1'b0;
      r_res_f      <= '0;
      r_ops_done   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_alu_a      <= w_head.a;
            r_alu_b      <= w_head.b;
            r_alu_select <= w_head.sub;
            r_state      <= DRIVE;
          end
        end
        DRIVE: begin
          r_res_f     <= alu_f;
          r_res_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (w_hs) begin
            r_res_valid <= 1'b0;
            r_ops_done  <= r_ops_done + 1'b1;
            if (!w_empty || w_push) begin
              r_alu_a      <= w_next_cmd.a;
              r_alu_b      <= w_next_cmd.b;
              r_alu_select <= w_next_cmd.sub;
              r_state      <= DRIVE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = reset_n & ~w_full;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_select = r_alu_select;
  assign res_valid  = r_res_valid;
  assign res_f      = r_res_f;
  assign ops_done   = r_ops_done;
  assign busy       = (r_state != IDLE) | (w_count != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 3-bit ALU that
// registers F on the falling clock edge.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_a;
  logic [2:0] cmd_b;
  logic       cmd_sub;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic       alu_select;
  logic [2:0] alu_f;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_f;
  logic       busy;
  logic [7:0] ops_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External ALU: shares reset_n, registers on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) alu_f <= 3'd0;
    else if (alu_select == SEL_SUB) alu_f <= alu_a - alu_b;
    else alu_f <= alu_a + alu_b;
  end

  alu_op_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_sub    (cmd_sub),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_f      (alu_f),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_f      (res_f),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b1; cmd_a = 3'd5; cmd_b = 3'd5; cmd_sub = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
      total++;
      if (alu_a !== 3'd0 || alu_b !== 3'd0) begin bad++; $display("FAIL reset_alu got a=%0d b=%0d exp 0 0", alu_a, alu_b); end
      total++;
      if (ops_done !== 8'd0) begin bad++; $display("FAIL reset_ops_done got=%0d exp=0", ops_done); end
    end
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL release_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_single();
    cmd_valid = 1'b1; cmd_a = 3'd3; cmd_b = 3'd2; cmd_sub = 1'b0; res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL single_t0_valid got=%b exp=0", res_valid); end
    tick();
    total++;
    if (alu_a !== 3'd3 || alu_b !== 3'd2 || alu_select !== 1'b0) begin
      bad++; $display("FAIL single_operands got a=%0d b=%0d sel=%b exp 3 2 0", alu_a, alu_b, alu_select);
    end
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL single_t1_valid got=%b exp=0", res_valid); end
    tick();
    total++;
    if (res_valid !== 1'b1 || res_f !== 3'd5) begin
      bad++; $display("FAIL single_result got valid=%b f=%0d exp 1 5", res_valid, res_f);
    end
    tick();
    total++;
    if (res_valid !== 1'b0 || ops_done !== 8'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_done got valid=%b ops=%0d busy=%b exp 0 1 0", res_valid, ops_done, busy);
    end
  endtask

  logic [2:0] wr_a   [3] = '{3'd7, 3'd1, 3'd0};
  logic [2:0] wr_b   [3] = '{3'd1, 3'd3, 3'd0};
  logic       wr_sub [3] = '{1'b0, 1'b1, 1'b1};
  logic [2:0] wr_exp [3] = '{3'd0, 3'd6, 3'd0};

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      bit seen;
      cmd_valid = 1'b1; cmd_a = wr_a[i]; cmd_b = wr_b[i]; cmd_sub = wr_sub[i]; res_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
        if (res_valid === 1'b1) seen = 1'b1;
        else tick();
      end
      total++;
      if (!seen) begin
        bad++; $display("FAIL wrap_timeout case=%0d got no res_valid exp res_valid=1", i);
      end else if (res_f !== wr_exp[i]) begin
        bad++; $display("FAIL wrap_result case=%0d got=%0d exp=%0d", i, res_f, wr_exp[i]);
      end
      tick();
      total++;
      if (ops_done !== 8'(2 + i)) begin
        bad++; $display("FAIL wrap_ops_done case=%0d got=%0d exp=%0d", i, ops_done, 2 + i);
      end
    end
  endtask

  logic [2:0] bb_a   [6] = '{3'd1, 3'd2, 3'd5, 3'd4, 3'd0, 3'd3};
  logic [2:0] bb_b   [6] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd1, 3'd3};
  logic       bb_sub [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [2:0] bb_exp [5] = '{3'd2, 3'd5, 3'd3, 3'd6, 3'd7};

  task automatic test_back_to_back();
    int accepted;
    accepted = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_a = bb_a[i]; cmd_b = bb_b[i]; cmd_sub = bb_sub[i];
      if (cmd_ready === 1'b1) accepted++;
      tick();
    end
    cmd_valid = 1'b0;
    total++;
    if (accepted != 5) begin bad++; $display("FAIL b2b_accepted got=%0d exp=5", accepted); end
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b exp=0", cmd_ready); end
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (res_valid !== 1'b1 || res_f !== bb_exp[0] || alu_a !== 3'd1 || alu_b !== 3'd1 || alu_select !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got valid=%b f=%0d a=%0d b=%0d sel=%b exp 1 2 1 1 0",
                 c, res_valid, res_f, alu_a, alu_b, alu_select);
      end
    end
    res_ready = 1'b1;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++; $display("FAIL bp_first_hs got ready=%b valid=%b exp 1 0", cmd_ready, res_valid);
    end
    for (int k = 1; k < 5; k++) begin
      tick();
      total++;
      if (res_valid !== 1'b1 || res_f !== bb_exp[k]) begin
        bad++; $display("FAIL bp_drain k=%0d got valid=%b f=%0d exp 1 %0d", k, res_valid, res_f, bb_exp[k]);
      end
      tick();
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_gap k=%0d got valid=%b exp=0", k, res_valid); end
    end
    total++;
    if (ops_done !== 8'd9 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_final got ops=%0d busy=%b exp 9 0", ops_done, busy);
    end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_a = bb_a[i]; cmd_b = bb_b[i]; cmd_sub = bb_sub[i];
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    total++;
    if (alu_a !== bb_a[1] || res_valid !== 1'b0 || ops_done !== 8'd10) begin
      bad++; $display("FAIL mid_drive got a=%0d valid=%b ops=%0d exp %0d 0 10", alu_a, res_valid, ops_done, bb_a[1]);
    end
    reset_n = 1'b0;
    tick();
    total++;
    if (res_valid !== 1'b0 || ops_done !== 8'd0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset got valid=%b ops=%0d busy=%b ready=%b exp 0 0 0 0",
                      res_valid, ops_done, busy, cmd_ready);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL mid_stale cyc=%0d got valid=%b busy=%b exp 0 0", c, res_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
